disp_bcd_seq: RTL

- Parametrised successor to the combinational 5-digit display decoder. Converts a signed or unsigned WIDTH-bit value to NDIG decimal digits using sequential double-dabble (shift-add-3).
- Drives NDIG+2 seven-segment displays: one letter, one sign slot, NDIG digits.
- Sits between the processor result/register bus and the board's HEX displays.
- Start/busy/done handshake. Display outputs are registered and held steady during conversion, so there is no flicker.

---
 rtl/disp_bcd_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/disp_bcd_seq.sv
// Sequential double-dabble converter driving NDIG+2 active-low seven-segment displays.
// Optional macro LZ_BLANK_EN: leading-zero blanking with a floating minus sign.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last formatted value
// CONV  | first cycle forms the magnitude, then one shift-add-3 step per cycle
// FMT   | builds the display fields; they register at the exit edge
module disp_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int NDIG   = 3,
  parameter int SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        num,
  input  logic [3:0]              letter,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [(NDIG+2)*7-1:0]   disp
);

  localparam int NFULL = (WIDTH * 30103) / 100000 + 1;
  localparam int NMAX  = (NFULL > NDIG) ? NFULL : NDIG;
  localparam int CW    = $clog2(WIDTH);
  localparam int DW    = (NDIG + 2) * 7;
  localparam int EW    = 4 * NMAX;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FMT  = 2'd2;

  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               prep_q, prep_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic [3:0]         letter_q, letter_d;
  logic [4*NFULL-1:0] bcd_q, bcd_d, bcd_adj;
  logic [DW-1:0]      disp_q, disp_d, fmt_disp;
  logic               ovf_q, ovf_d, fmt_ovf;
  logic               done_q, done_d;
  logic [EW-1:0]      bcd_ext;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NFULL; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_ext = EW'(bcd_q);

`ifdef LZ_BLANK_EN
  int msd;
`endif

  always_comb begin
    fmt_ovf  = 1'b0;
    fmt_disp = {DW{1'b1}};
    for (int i = NDIG; i < NMAX; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) fmt_ovf = 1'b1;
    end
    fmt_disp[7*(NDIG+1) +: 7] = seg7(letter_q);
`ifdef LZ_BLANK_EN
    msd = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) msd = i;
    end
`endif
    if (fmt_ovf) begin
      for (int i = 0; i < NDIG; i++) fmt_disp[7*i +: 7] = G_DASH;
    end else begin
`ifdef LZ_BLANK_EN
      for (int i = 0; i < NDIG; i++) begin
        if (i <= msd) fmt_disp[7*i +: 7] = seg7(bcd_ext[4*i +: 4]);
      end
      // Sign floats to the field just left of the top shown digit (may be the sign slot).
      if (neg_q) fmt_disp[7*(msd+1) +: 7] = G_DASH;
`else
      for (int i = 0; i < NDIG; i++) fmt_disp[7*i +: 7] = seg7(bcd_ext[4*i +: 4]);
      fmt_disp[7*NDIG +: 7] = neg_q ? G_DASH : G_BLANK;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prep_d   = prep_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    letter_d = letter_q;
    bcd_d    = bcd_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CONV;
          prep_d   = 1'b1;
          mag_d    = num;
          neg_d    = (SIGNED != 0) && num[WIDTH-1];
          letter_d = letter;
          bcd_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
        end
      end
      S_CONV: begin
        // Negation happens here rather than at capture to keep the adder off the num input path.
        if (prep_q) begin
          prep_d = 1'b0;
          if (neg_q) mag_d = ~mag_q + WIDTH'(1);
        end else begin
          bcd_d = {bcd_adj[4*NFULL-2:0], mag_q[WIDTH-1]};
          mag_d = {mag_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FMT;
        end
      end
      S_FMT: begin
        disp_d  = fmt_disp;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prep_q   <= 1'b0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      letter_q <= '0;
      bcd_q    <= '0;
      disp_q   <= {DW{1'b1}};
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prep_q   <= prep_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      letter_q <= letter_d;
      bcd_q    <= bcd_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign disp = disp_q;

endmodule
